// File: rtl/mips_pkg.sv
// Shared core types: register file widths, write-back entry, register names.
package mips_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  localparam logic [REG_ADDR_W-1:0] S0 = 4'd0;
  localparam logic [REG_ADDR_W-1:0] S1 = 4'd1;
  localparam logic [REG_ADDR_W-1:0] S2 = 4'd2;
  localparam logic [REG_ADDR_W-1:0] S3 = 4'd3;
  localparam logic [REG_ADDR_W-1:0] S4 = 4'd4;
  localparam logic [REG_ADDR_W-1:0] S5 = 4'd5;
  localparam logic [REG_ADDR_W-1:0] S6 = 4'd6;
  localparam logic [REG_ADDR_W-1:0] S7 = 4'd7;
  localparam logic [REG_ADDR_W-1:0] T0 = 4'd8;
  localparam logic [REG_ADDR_W-1:0] T1 = 4'd9;
  localparam logic [REG_ADDR_W-1:0] T2 = 4'd10;
  localparam logic [REG_ADDR_W-1:0] T3 = 4'd11;
  localparam logic [REG_ADDR_W-1:0] T4 = 4'd12;
  localparam logic [REG_ADDR_W-1:0] T5 = 4'd13;
  localparam logic [REG_ADDR_W-1:0] T6 = 4'd14;
  localparam logic [REG_ADDR_W-1:0] T7 = 4'd15;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry FIFO: two enqueues (port 0 first), one dequeue,
// synchronous flush; exposes every slot and its valid bit.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 36,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push0,
  input  logic [W-1:0]  i_d0,
  input  logic          i_push1,
  input  logic [W-1:0]  i_d1,
  input  logic          i_pop,
  output logic [CW-1:0] o_level,
  output logic [W-1:0]  o_head,
  output logic [W-1:0]  o_ent [DEPTH],
  output logic [DEPTH-1:0] o_vld
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic          w_p0;
  logic          w_p1;
  logic          w_pop;
  logic [CW-1:0] w_n;
  logic [W-1:0]  w_first;
  logic [PW-1:0] w_wr1;

  assign w_p0    = i_push0 & ~i_flush;
  assign w_p1    = i_push1 & ~i_flush;
  assign w_pop   = i_pop & (r_cnt != '0);
  assign w_n     = CW'(w_p0) + CW'(w_p1);
  assign w_first = w_p0 ? i_d0 : i_d1;
  assign w_wr1   = r_wr + PW'(1);

  // Storage carries no reset: a slot is only observed while counted valid.
  always_ff @(posedge i_clk) begin
    if (w_p0 | w_p1)
      r_mem[r_wr] <= w_first;
    if (w_p0 & w_p1)
      r_mem[w_wr1] <= i_d1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + PW'(w_n);
      r_rd  <= r_rd + PW'(w_pop);
      r_cnt <= r_cnt + w_n - CW'(w_pop);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] w_off;
    assign w_off    = PW'(g) - r_rd;
    assign o_vld[g] = {1'b0, w_off} < r_cnt;
  end

  assign o_level = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign o_ent   = r_mem;

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue feeding the register file write port.
// Define WB_HAZARD_EN to build the pending-write hazard comparators.
module writeback_queue
  import mips_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = mips_pkg::DATA_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int EW     = ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] chk_addr_a,
  input  logic [ADDR_W-1:0] chk_addr_b,
  output logic              hazard,
  output logic              write,
  output logic [ADDR_W-1:0] Adr_register_to_save,
  output logic [DATA_W-1:0] data_from_ctrl,
  output logic [CW-1:0]     level
);

  logic [CW-1:0]    w_level;
  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_ent [DEPTH];
  logic [DEPTH-1:0] w_vld;
  logic [CW:0]      w_free;
  logic             w_write;

  assign w_write = (w_level != '0);
  // Slots available this cycle count the head leaving at the same edge.
  assign w_free  = (CW+1)'(DEPTH) - {1'b0, w_level} + (CW+1)'(w_write);

  assign alu_ready = rst & ~flush & (w_free >= (CW+1)'(1));
  assign mem_ready = rst & ~flush &
                     (w_free >= (CW+1)'(1) + (CW+1)'(alu_valid));

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (flush),
    .i_push0 (alu_valid & alu_ready),
    .i_d0    ({alu_addr, alu_data}),
    .i_push1 (mem_valid & mem_ready),
    .i_d1    ({mem_addr, mem_data}),
    .i_pop   (w_write),
    .o_level (w_level),
    .o_head  (w_head),
    .o_ent   (w_ent),
    .o_vld   (w_vld)
  );

  assign write                = w_write;
  assign level                = w_level;
  assign Adr_register_to_save = w_write ? w_head[EW-1:DATA_W] : '0;
  assign data_from_ctrl       = w_write ? w_head[DATA_W-1:0] : '0;

`ifdef WB_HAZARD_EN
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i] &&
          (w_ent[i][EW-1:DATA_W] == chk_addr_a ||
           w_ent[i][EW-1:DATA_W] == chk_addr_b))
        hazard = 1'b1;
    end
  end
`else
  logic w_unused_hz;
  always_comb begin
    w_unused_hz = ^{chk_addr_a, chk_addr_b, w_vld};
    for (int i = 0; i < DEPTH; i++)
      w_unused_hz = w_unused_hz ^ (^w_ent[i]);
  end
  assign hazard = 1'b0;
`endif

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-back stage directly upstream of the register file. It collects register results from the ALU path and the memory-load path, buffers them in order, and drives the register file write port with at most one write per cycle. It also reports pending writes to decode, so decode can stall instead of reading a stale register.

## Interface
- DEPTH, 4, number of queued entries (power of two, ≥2)
- DATA_W, 32, result width
- ADDR_W, 4, register address width (16 registers: s0–s7 at 0–7, t0–t7 at 8–15)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this posedge when alu_valid=1
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this posedge when mem_valid=1
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- flush  in  1  synchronous discard of all queued entries
- chk_addr_a, chk_addr_b  in  ADDR_W  decode source addresses to check
- hazard  out  1  a queued entry targets chk_addr_a or chk_addr_b
- write  out  1  register file write enable
- Adr_register_to_save  out  ADDR_W  register file write address
- data_from_ctrl  out  DATA_W  register file write data
- level  out  $clog2(DEPTH)+1  current entry count

## Operation
- The FIFO holds {addr, data} entries.
- The head entry drives the write port directly from flops:
  - write = (level != 0)
  - Adr_register_to_save and data_from_ctrl = head fields
  - When level = 0, the address and data outputs are 0.
- Pop: every posedge with write=1 removes the head. The register file samples the head at the intervening negedge.
- Free slots this cycle: free = DEPTH − level + write.
- Ready signals:
  - alu_ready = rst & !flush & (free ≥ 1)
  - mem_ready = rst & !flush & (free ≥ 1 + alu_valid)
- Same-cycle acceptance:
  - Both producers can be accepted in the same cycle.
  - The ALU entry is enqueued ahead of the mem entry.
  - The ALU has priority when only one slot is free.
- Entries for the same address are written in enqueue order, so the last write wins. There is no merging.
- Flush:
  - At the next posedge, level becomes 0 and all entries are dropped, including the head.
  - No input is accepted in the flush cycle.
- hazard = OR over valid entries (head included) of (entry.addr == chk_addr_a) | (entry.addr == chk_addr_b).
  - It is combinational from flops and the chk inputs.
  - It is 0 when level = 0.
- level: +1 or +2 per accepted input, −1 per pop, saturating at DEPTH by construction. The read and write pointers wrap modulo DEPTH.

## Timing
- Reset (rst low): level=0, write=0, Adr_register_to_save=0, data_from_ctrl=0, hazard=0, alu_ready=0, mem_ready=0. Pointers are cleared.
- After release, the first posedge can accept input.
- Reset asserted mid-operation discards all entries immediately. A write in progress is dropped: write falls asynchronously.
- Latency: with an empty queue, an entry accepted at posedge N drives write=1 during cycle N→N+1 and reaches the register file at the negedge of that cycle.
- Throughput: one write per cycle. Two producers every cycle fill the queue after DEPTH−1 cycles; mem_ready then drops while alu_valid=1.
- Full (level=DEPTH): the concurrent pop gives free=1, so exactly one input is accepted.
- Empty: write=0; no pop.
- Valid and data must hold stable until ready is seen high at the posedge. Ready must not be used to generate valid.

## Configuration
- WB_HAZARD_EN defined: address comparators and the hazard output are built as described.
- WB_HAZARD_EN undefined: hazard is tied 0, chk_addr_a/chk_addr_b are ignored, and no comparators are synthesized. In this build, decode must stall on level != 0 instead.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W=4, DATA_W=32
  - wb_entry_t struct {addr, data}
  - register index constants S0..S7 = 0..7, T0..T7 = 8..15
- Sub-module wb_fifo: the generic DEPTH-entry, dual-enqueue, single-dequeue FIFO (storage, pointers, count, flush).
- writeback_queue adds the ready logic, port mapping and hazard compare.

## Test plan
- Reset, then ALU writes addr 3 / data 0xDEADBEEF → write=1, Adr_register_to_save=3, data_from_ctrl=0xDEADBEEF for exactly one cycle; level returns to 0.
- alu and mem valid in the same cycle (ALU addr 8 / data 0x11, mem addr 8 / data 0x22) → two writes in order, 0x11 then 0x22; hazard with chk_addr_a=8 stays high until both are written.
- Both producers valid continuously with DEPTH=4 → level reaches 4, mem_ready=0 while alu_ready=1; no entry lost or reordered (compare against a scoreboard).
- Fill to level 3, assert flush for one cycle with alu_valid=1 → alu_ready=0, next cycle level=0, write=0; data is not written.
- Assert rst low while level=2 → write drops immediately and all outputs are 0; after release, new entry addr 15 / data 0x5 writes correctly.
- Compile without WB_HAZARD_EN and set chk_addr_b to the queued address → hazard stays 0.
